// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word adder sequencer: FSM state
// encodings and helpers that derive the operand and index widths.
package multiword_add_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full operand width built from one slice width and the slice count.
    function automatic int calc_w(input int n, input int words);
        return n * words;
    endfunction

    // Word index width; a single-word configuration still needs one bit.
    function automatic int calc_iw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_rca.sv
// N-bit ripple-carry adder slice. Purely combinational; the sequencer
// reuses this single slice once per operand word.
module Ripple_Carry_Adder #(
    parameter int N = 10
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    // Bit-serial carry chain from bit 0 up to bit N-1.
    always_comb begin
        logic v_c;
        o_sum = '0;
        v_c   = i_cin;
        for (int i = 0; i < N; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ v_c;
            v_c      = (i_a[i] & i_b[i]) | (v_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = v_c;
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide adder built by stepping one N-bit ripple-carry slice across WORDS
// operand words, least-significant word first, with the carry held in a
// register between steps. Start/Done handshake toward the requester:
//   Start is accepted only when Busy=0 (IDLE or DONE); a Start seen while
//   Busy=1 is dropped. Done is a one-cycle pulse marking Result/Cout valid,
//   and both hold until the next accepted Start. Busy and Done never overlap.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int N     = 10,
    parameter int WORDS = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [N*WORDS-1:0]   Inp1,
    input  logic [N*WORDS-1:0]   Inp2,
    input  logic                 Cin,
    output logic                 Busy,
    output logic                 Done,
    output logic [N*WORDS-1:0]   Result,
    output logic                 Cout
);

    localparam int W  = calc_w(N, WORDS);
    localparam int IW = calc_iw(WORDS);

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_result;
    logic            r_cout;

    logic            w_accept;
    logic            w_last;
    logic [N-1:0]    w_a_word;
    logic [N-1:0]    w_b_word;
    logic [N-1:0]    w_sum;
    logic            w_slice_cout;

    assign w_accept = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_idx == IW'(WORDS - 1));
    assign w_a_word = r_a[r_idx*N +: N];
    assign w_b_word = r_b[r_idx*N +: N];

    Ripple_Carry_Adder #(.N(N)) u_slice (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_slice_cout)
    );

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN exits after the last word, DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (Start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = Start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture on accept, then one word of sum per RUN cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= Inp1;
            r_b     <= Inp2;
            r_carry <= Cin;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_result[r_idx*N +: N] <= w_sum;
            r_carry                <= w_slice_cout;
            if (w_last) begin
                // Index stays put on the last word so it never wraps.
                r_cout <= w_slice_cout;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign Busy   = (r_state == ST_RUN);
    assign Done   = (r_state == ST_DONE);
    assign Result = r_result;
    assign Cout   = r_cout;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer (N=10, WORDS=4). A transaction-level
// model tracks how many RUN cycles remain for the operation in flight and
// the exact W+1-bit sum it must deliver; a compare process checks the DUT
// against that model on every falling edge. Directed cases pin the model
// with hand-computed literals, then a randomized phase follows.
module tb_multiword_add_sequencer;

    localparam int N     = 10;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic          clk;
    logic          rst;
    logic          Start;
    logic [W-1:0]  Inp1;
    logic [W-1:0]  Inp2;
    logic          Cin;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Result;
    logic          Cout;

    int checks = 0;
    int errors = 0;

    multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .Clk    (clk),
        .Rst    (rst),
        .Start  (Start),
        .Inp1   (Inp1),
        .Inp2   (Inp2),
        .Cin    (Cin),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result),
        .Cout   (Cout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_left: RUN cycles still owed to the accepted operation (0 = not busy).
    int            m_left = 0;
    logic          m_done = 1'b0;
    logic [W-1:0]  m_res  = '0;
    logic          m_cout = 1'b0;
    logic [W:0]    exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_cout = 1'b0;
            exp_q.delete();
        end else begin
            logic       acc;
            logic [W:0] s;
            acc    = Start && (m_left == 0);
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    s      = exp_q.pop_front();
                    m_res  = s[W-1:0];
                    m_cout = s[W];
                    m_done = 1'b1;
                end
            end
            if (acc) begin
                exp_q.push_back({1'b0, Inp1} + {1'b0, Inp2} + {{W{1'b0}}, Cin});
                m_left = WORDS;
            end
        end
    end

    // Compare process: Result/Cout are only required stable when not busy.
    always @(negedge clk) begin
        check("busy", {63'd0, Busy}, {63'd0, (m_left > 0)});
        check("done", {63'd0, Done}, {63'd0, m_done});
        check("busy_done_excl", {63'd0, Busy & Done}, 64'd0);
        if (m_left == 0) begin
            check("result", {24'd0, Result}, {24'd0, m_res});
            check("cout", {63'd0, Cout}, {63'd0, m_cout});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold Start for one sampling edge, then scramble the inputs.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        Start = 1'b1;
        Inp1  = a;
        Inp2  = b;
        Cin   = c;
        step();
        Start = 1'b0;
        Inp1  = rand40();
        Inp2  = rand40();
        Cin   = 1'($urandom_range(0, 1));
    endtask

    // Counts falling edges until Done is seen (bounded).
    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!Done && n < max);
        check("done_seen", {63'd0, Done}, 64'd1);
    endtask

    function automatic logic [W-1:0] rand40();
        logic [63:0] v;
        int          mode;
        mode = $urandom_range(0, 5);
        v    = {$urandom, $urandom};
        case (mode)
            0:       return '1;
            1:       return '0;
            default: return v[W-1:0];
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int done_cnt;
        rst   = 1'b1;
        Start = 1'b0;
        Inp1  = '0;
        Inp2  = '0;
        Cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_result", {24'd0, Result}, 64'd0);
        check("rst_cout", {63'd0, Cout}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // 1: basic add, latency WORDS+1 from the Start cycle
        issue(40'd250, 40'd400, 1'b0);
        wait_done(20, n);
        check("t1_latency", 64'(n), 64'd5);
        check("t1_result", {24'd0, Result}, 64'd650);
        check("t1_cout", {63'd0, Cout}, 64'd0);
        step();

        // 2: carry-in
        issue(40'd250, 40'd400, 1'b1);
        wait_done(20, n);
        check("t2_result", {24'd0, Result}, 64'd651);
        check("t2_cout", {63'd0, Cout}, 64'd0);
        step();

        // 3: carry through every slice
        issue(40'hFF_FFFF_FFFF, 40'd1, 1'b0);
        wait_done(20, n);
        check("t3_result", {24'd0, Result}, 64'd0);
        check("t3_cout", {63'd0, Cout}, 64'd1);
        step();

        // 4: Start during RUN is ignored
        issue(40'd750, 40'd300, 1'b0);
        step();
        Start = 1'b1;
        Inp1  = 40'd12345;
        Inp2  = 40'd777;
        step();
        Start = 1'b0;
        wait_done(20, n);
        check("t4_latency", 64'(n), 64'd3);
        check("t4_result", {24'd0, Result}, 64'd1050);
        check("t4_cout", {63'd0, Cout}, 64'd0);

        // 5: Start in the Done cycle is accepted
        issue(40'd1, 40'd2, 1'b0);
        wait_done(20, n);
        check("t5_latency", 64'(n), 64'd5);
        check("t5_result", {24'd0, Result}, 64'd3);
        step();

        // 6: reset mid-RUN aborts immediately, no Done afterwards
        issue(40'h12_3456_789A, 40'h01_0101_0101, 1'b1);
        step();
        step();
        rst = 1'b1;
        #1;
        check("t6_busy", {63'd0, Busy}, 64'd0);
        check("t6_result", {24'd0, Result}, 64'd0);
        check("t6_cout", {63'd0, Cout}, 64'd0);
        #2;
        rst = 1'b0;
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (Done) done_cnt++;
        end
        check("t6_no_done", 64'(done_cnt), 64'd0);
        step();
        issue(40'd100, 40'd23, 1'b0);
        wait_done(20, n);
        check("t6_after_result", {24'd0, Result}, 64'd123);
        step();

        // Randomized phase: random Start density, operands, rare resets
        for (int i = 0; i < 1500; i++) begin
            Start = ($urandom_range(0, 2) == 0);
            Inp1  = rand40();
            Inp2  = rand40();
            Cin   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            step();
        end
        Start = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
